m_fetch_unit: RTL



---
 rtl/m_fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/m_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/gnt/rvalid, holds one instruction for the controller.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module m_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [31:0]       i_imem_rdata,
    output logic              o_valid,
    output logic [31:0]       o_instr,
    output logic [2:0]        o_opt,
    output logic [ADDR_W-1:0] o_pc,
    input  logic              i_stall,
    input  logic              i_br_taken,
    input  logic [ADDR_W-1:0] i_br_target,
    output logic [31:0]       o_perf_fetched,
    output logic [31:0]       o_perf_flushed
);

    // Handshake: a fetch transfers when o_imem_req & i_imem_gnt; exactly one i_imem_rvalid
    // follows per grant; downstream consumes when o_valid & ~i_stall.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_pend_pc;
    logic              r_kill;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_out_pc;
    logic [ADDR_W-1:0] w_tgt;

    assign w_tgt = i_br_target & ~ADDR_W'(3);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_REQ: begin
                if (i_imem_gnt) w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    w_next_state = (r_kill || i_br_taken) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_br_taken || !i_stall) w_next_state = S_REQ;
            end
            default: w_next_state = S_REQ;
        endcase
    end

    // Redirects in REQ/WAIT are parked in r_pend_pc until the in-flight response drains.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_kill     <= 1'b0;
            r_instr    <= '0;
            r_out_pc   <= RESET_PC;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_br_taken) begin
                        r_kill    <= 1'b1;
                        r_pend_pc <= w_tgt;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (r_kill || i_br_taken) begin
                            r_kill     <= 1'b0;
                            r_fetch_pc <= i_br_taken ? w_tgt : r_pend_pc;
                        end else begin
                            r_instr  <= i_imem_rdata;
                            r_out_pc <= r_fetch_pc;
                        end
                    end else if (i_br_taken) begin
                        r_kill    <= 1'b1;
                        r_pend_pc <= w_tgt;
                    end
                end
                S_HOLD: begin
                    if (i_br_taken) begin
                        r_fetch_pc <= w_tgt;
                    end else if (!i_stall) begin
                        r_fetch_pc <= r_out_pc + ADDR_W'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by reset so no request leaks out while the block is held in reset.
    assign o_imem_req  = i_rst_n && (r_state == S_REQ);
    assign o_imem_addr = r_fetch_pc;
    assign o_valid     = (r_state == S_HOLD);
    assign o_instr     = r_instr;
    assign o_opt       = r_instr[31:29];
    assign o_pc        = r_out_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic        w_consume;
    logic        w_flush;

    assign w_consume = (r_state == S_HOLD) && !i_br_taken && !i_stall;
    assign w_flush   = ((r_state == S_WAIT) && i_imem_rvalid && (r_kill || i_br_taken))
                     || ((r_state == S_HOLD) && i_br_taken);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            if (w_consume) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_flush)   r_perf_flushed <= r_perf_flushed + 32'd1;
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_flushed = r_perf_flushed;
`else
    assign o_perf_fetched = 32'd0;
    assign o_perf_flushed = 32'd0;
`endif

endmodule
